// File: rtl/mul16_seq.sv
// Sequential 16x16 unsigned shift-and-add multiplier driving a 16-bit
// carry-lookahead adder, with a start/busy/done handshake.

module adder (
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] Sum
);
  logic [3:0] gg, pg, cg;

  // Group carries are fully expanded so no net feeds back on itself.
  assign cg[0] = 1'b0;
  assign cg[1] = gg[0];
  assign cg[2] = gg[1] | (pg[1] & gg[0]);
  assign cg[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]);

  for (genvar k = 0; k < 4; k++) begin : g_grp
    logic [3:0] g, p, c;
    assign g = A[4*k +: 4] & B[4*k +: 4];
    assign p = A[4*k +: 4] ^ B[4*k +: 4];
    assign c[0] = cg[k];
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign gg[k] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);
    assign pg[k] = &p;
    assign Sum[4*k +: 4] = p ^ c;
  end
endmodule

module mul16_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [15:0] mcand, hi, lo;
  logic [4:0]  cnt;
  logic [15:0] addend, sum;
  logic        carry;
  logic [31:0] next_hilo;

  assign addend = lo[0] ? mcand : '0;

  adder u_adder (
    .A  (hi),
    .B  (addend),
    .Sum(sum)
  );

  // The adder has no carry-out; rebuild it from the MSBs of operands and sum.
  assign carry     = (hi[15] & addend[15]) | ((hi[15] ^ addend[15]) & ~sum[15]);
  assign next_hilo = {carry, sum, lo[15:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= a;
            hi    <= '0;
            lo    <= b;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          {hi, lo} <= next_hilo;
          cnt      <= cnt + 5'd1;
          if (cnt == 5'd15) begin
            product <= next_hilo;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul16_seq.sv
// Scoreboard bench for mul16_seq: the driver queues a*b at each accept and a
// negedge monitor checks product, latency, busy and product stability.

module tb_mul16_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] product;

  typedef struct {
    logic [31:0] prod;
    int          acc_cyc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] last_product = '0;
  logic        prev_done = 1'b0;

  mul16_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("product", product, e.prod);
          chk("latency", 32'(cyc - e.acc_cyc), 32'd16);
          chk("busy_at_done", {31'd0, busy}, 32'd0);
        end
        chk("done_one_cycle", {31'd0, prev_done}, 32'd0);
        last_product = product;
      end else begin
        chk("product_stable", product, last_product);
        if (q.size() > 0) chk("busy_in_run", {31'd0, busy}, 32'd1);
      end
      prev_done = done;
    end
  end

  task automatic issue(input logic [15:0] x, input logic [15:0] y);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("accept_timeout", 32'd1, 32'd0);
    start = 1'b1;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    e.prod    = 32'(x) * 32'(y);
    e.acc_cyc = cyc;
    q.push_back(e);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #12;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_product", product, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(16'd3, 16'd5);
    drain();
    issue(16'hFFFF, 16'hFFFF);
    drain();
    issue(16'h8000, 16'h0002);
    drain();
    issue(16'h0000, 16'h1234);
    drain();

    // Start pulse during RUN must be ignored.
    issue(16'd7, 16'd9);
    repeat (5) @(negedge clk);
    start = 1'b1;
    a = 16'd2;
    b = 16'd2;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    // Back-to-back: second issue lands on the done cycle.
    issue(16'd100, 16'd200);
    issue(16'd10, 16'd11);
    drain();

    // Asynchronous reset mid-run.
    issue(16'd1234, 16'd5678);
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_product", product, 32'd0);
    q.delete();
    last_product = '0;
    prev_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    issue(16'd2, 16'd3);
    drain();

    // Randomized operands with random gaps, some back-to-back.
    for (int i = 0; i < 25; i++) begin
      issue(16'($urandom), 16'($urandom));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 25)) @(negedge clk);
    end
    drain();
    issue(16'hFFFF, 16'h0001);
    issue(16'h0001, 16'hFFFF);
    drain();
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
